// File: rtl/donut_ray_sequencer.sv
// Raster-order initiator for the torus ray-march hit-test unit: issues one march per
// pixel, waits a fixed latency, then emits a 4-bit shade over a valid/ready handshake.
module donut_ray_sequencer #(
  parameter int unsigned        W            = 40,
  parameter int unsigned        H            = 24,
  parameter logic signed [15:0] RX_STEP      = 16'sd24,
  parameter logic signed [15:0] RY_STEP      = 16'sd40,
  parameter int unsigned        MARCH_CYCLES = 8,
  localparam int unsigned       CW           = (W > 1) ? $clog2(W) : 1,
  localparam int unsigned       RW           = (H > 1) ? $clog2(H) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic signed [15:0]  cam_px,
  input  logic signed [15:0]  cam_py,
  input  logic signed [15:0]  cam_pz,
  input  logic signed [15:0]  rx_base,
  input  logic signed [15:0]  ry_base,
  input  logic signed [15:0]  rz_fixed,
  input  logic signed [15:0]  lx_in,
  input  logic signed [15:0]  ly_in,
  input  logic signed [15:0]  lz_in,
  output logic                march_start,
  output logic signed [15:0]  px_o,
  output logic signed [15:0]  py_o,
  output logic signed [15:0]  pz_o,
  output logic signed [15:0]  rx_o,
  output logic signed [15:0]  ry_o,
  output logic signed [15:0]  rz_o,
  output logic signed [15:0]  lx_o,
  output logic signed [15:0]  ly_o,
  output logic signed [15:0]  lz_o,
  input  logic                march_hit,
  input  logic signed [15:0]  march_light,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic [3:0]          pix_shade,
  output logic [CW-1:0]       pix_col,
  output logic [RW-1:0]       pix_row,
  output logic                pix_last,
  output logic                busy,
  output logic                frame_done
);

  localparam int unsigned MW = $clog2(MARCH_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_MARCH,
    S_EMIT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [MW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic signed [15:0] px_q, px_d, py_q, py_d, pz_q, pz_d;
  logic signed [15:0] rx_q, rx_d, ry_q, ry_d, rz_q, rz_d;
  logic signed [15:0] lx_q, lx_d, ly_q, ly_d, lz_q, lz_d;
  logic [3:0]         shade_q, shade_d;
  logic               last_q, last_d;
  logic               march_start_q, pix_valid_q, busy_q, frame_done_q;

  function automatic logic [3:0] shade_f(input logic hit, input logic signed [15:0] light);
    logic signed [15:0] q;
    q = light >>> 7;
    if (!hit)                  shade_f = 4'd0;
    else if (light <= 16'sd0)  shade_f = 4'd1;
    else if (q >= 16'sd14)     shade_f = 4'd15;
    else                       shade_f = q[3:0] + 4'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    px_d    = px_q;
    py_d    = py_q;
    pz_d    = pz_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    rz_d    = rz_q;
    lx_d    = lx_q;
    ly_d    = ly_q;
    lz_d    = lz_q;
    shade_d = shade_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          px_d    = cam_px;
          py_d    = cam_py;
          pz_d    = cam_pz;
          rx_d    = rx_base;
          ry_d    = ry_base;
          rz_d    = rz_fixed;
          lx_d    = lx_in;
          ly_d    = ly_in;
          lz_d    = lz_in;
          col_d   = '0;
          row_d   = '0;
          last_d  = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_MARCH;
      end
      S_MARCH: begin
        // Final march cycle: the hit-test result is valid now, so fold it straight into the shade.
        if (cnt_q == MW'(MARCH_CYCLES - 1)) begin
          shade_d = shade_f(march_hit, march_light);
          last_d  = (col_q == CW'(W - 1)) && (row_q == RW'(H - 1));
          state_d = S_EMIT;
        end else begin
          cnt_d = cnt_q + MW'(1);
        end
      end
      S_EMIT: begin
        if (pix_ready) begin
          if (last_q) begin
            state_d = S_DONE;
          end else if (col_q == CW'(W - 1)) begin
            col_d   = '0;
            row_d   = row_q + RW'(1);
            rx_d    = rx_base;
            ry_d    = ry_q + RY_STEP;
            state_d = S_ISSUE;
          end else begin
            col_d   = col_q + CW'(1);
            rx_d    = rx_q + RX_STEP;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they stay registered yet align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      col_q         <= '0;
      row_q         <= '0;
      px_q          <= '0;
      py_q          <= '0;
      pz_q          <= '0;
      rx_q          <= '0;
      ry_q          <= '0;
      rz_q          <= '0;
      lx_q          <= '0;
      ly_q          <= '0;
      lz_q          <= '0;
      shade_q       <= '0;
      last_q        <= 1'b0;
      march_start_q <= 1'b0;
      pix_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      col_q         <= col_d;
      row_q         <= row_d;
      px_q          <= px_d;
      py_q          <= py_d;
      pz_q          <= pz_d;
      rx_q          <= rx_d;
      ry_q          <= ry_d;
      rz_q          <= rz_d;
      lx_q          <= lx_d;
      ly_q          <= ly_d;
      lz_q          <= lz_d;
      shade_q       <= shade_d;
      last_q        <= last_d;
      march_start_q <= (state_d == S_ISSUE);
      pix_valid_q   <= (state_d == S_EMIT);
      busy_q        <= (state_d != S_IDLE);
      frame_done_q  <= (state_d == S_DONE);
    end
  end

  assign march_start = march_start_q;
  assign px_o        = px_q;
  assign py_o        = py_q;
  assign pz_o        = pz_q;
  assign rx_o        = rx_q;
  assign ry_o        = ry_q;
  assign rz_o        = rz_q;
  assign lx_o        = lx_q;
  assign ly_o        = ly_q;
  assign lz_o        = lz_q;
  assign pix_valid   = pix_valid_q;
  assign pix_shade   = shade_q;
  assign pix_col     = col_q;
  assign pix_row     = row_q;
  assign pix_last    = last_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_donut_ray_sequencer.sv
// Directed bench for donut_ray_sequencer on a 4x2 grid with a table-driven hit-test stub.
module tb_donut_ray_sequencer;

  localparam logic signed [15:0] PX  = 16'sh0100;
  localparam logic signed [15:0] PY  = -16'sh0080;
  localparam logic signed [15:0] PZ  = -16'sh0400;
  localparam logic signed [15:0] RXB = -16'sd512;
  localparam logic signed [15:0] RYB = -16'sd256;
  localparam logic signed [15:0] RZ  = 16'sh0100;
  localparam logic signed [15:0] LX  = 16'sh0093;
  localparam logic signed [15:0] LY  = -16'sh0050;
  localparam logic signed [15:0] LZ  = 16'sh0020;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, frame_start, march_hit, pix_ready;
  logic signed [15:0] cam_px, cam_py, cam_pz, rx_base, ry_base, rz_fixed;
  logic signed [15:0] lx_in, ly_in, lz_in, march_light;
  logic               march_start, pix_valid, pix_last, busy, frame_done;
  logic signed [15:0] px_o, py_o, pz_o, rx_o, ry_o, rz_o, lx_o, ly_o, lz_o;
  logic [3:0]         pix_shade;
  logic [1:0]         pix_col;
  logic [0:0]         pix_row;

  donut_ray_sequencer #(
    .W(4), .H(2), .RX_STEP(16'sd64), .RY_STEP(16'sd128), .MARCH_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .cam_px(cam_px), .cam_py(cam_py), .cam_pz(cam_pz),
    .rx_base(rx_base), .ry_base(ry_base), .rz_fixed(rz_fixed),
    .lx_in(lx_in), .ly_in(ly_in), .lz_in(lz_in),
    .march_start(march_start),
    .px_o(px_o), .py_o(py_o), .pz_o(pz_o),
    .rx_o(rx_o), .ry_o(ry_o), .rz_o(rz_o),
    .lx_o(lx_o), .ly_o(ly_o), .lz_o(lz_o),
    .march_hit(march_hit), .march_light(march_light),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_shade(pix_shade),
    .pix_col(pix_col), .pix_row(pix_row), .pix_last(pix_last),
    .busy(busy), .frame_done(frame_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ms_cnt = 0;
  int fd_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (march_start === 1'b1) ms_cnt <= ms_cnt + 1;
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic wait_march();
    int n = 0;
    while (march_start !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("march_start seen", 32'(march_start), 32'd1);
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  logic               hit_t[8]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic signed [15:0] light_t[8] = '{16'sd500, -16'sd100, 16'sd384, 16'sd4000,
                                     16'sd100, 16'sd1791, 16'sd1920, 16'sd128};
  int                 shade_t[8] = '{0, 1, 4, 15, 1, 14, 15, 2};

  initial begin
    logic signed [15:0] ex_rx, ex_ry;
    logic               stable;
    int                 t_prev;
    rst_n = 1'b0; frame_start = 1'b0; pix_ready = 1'b1;
    march_hit = 1'b0; march_light = '0;
    cam_px = PX; cam_py = PY; cam_pz = PZ;
    rx_base = RXB; ry_base = RYB; rz_fixed = RZ;
    lx_in = LX; ly_in = LY; lz_in = LZ;
    t_prev = 0;
    repeat (3) @(negedge clk);
    check("rst march_start", 32'(march_start), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst pix_valid", 32'(pix_valid), 32'd0);
    check("rst rx_o", 32'(rx_o), 32'd0);
    check("rst lx_o", 32'(lx_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Frame 1: full 4x2 scan with stall, ignored frame_start pulses and light toggling.
    pulse_frame_start();
    for (int p = 0; p < 8; p++) begin
      wait_march();
      march_hit   = hit_t[p];
      march_light = light_t[p];
      if (p > 0) check("start spacing", 32'(cyc - t_prev), (p == 2) ? 32'd30 : 32'd10);
      t_prev = cyc;
      ex_rx = RXB + 16'(64 * (p % 4));
      ex_ry = RYB + 16'(128 * (p / 4));
      check("rx_o", 32'(rx_o), 32'(ex_rx));
      check("ry_o", 32'(ry_o), 32'(ex_ry));
      if (p == 0) begin
        check("px_o", 32'(px_o), 32'(PX));
        check("rz_o", 32'(rz_o), 32'(RZ));
        check("lz_o", 32'(lz_o), 32'(LZ));
        check("busy in frame", 32'(busy), 32'd1);
      end
      lx_in = lx_in + 16'sd1;
      if (p == 1) pix_ready = 1'b0;
      stable = 1'b1;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (p == 2 && k == 3) frame_start = 1'b1;
        if (p == 2 && k == 4) frame_start = 1'b0;
        stable &= (rx_o == ex_rx) && (ry_o == ex_ry) && (rz_o == RZ) &&
                  (px_o == PX) && (py_o == PY) && (pz_o == PZ) &&
                  (lx_o == LX) && (ly_o == LY) && (lz_o == LZ) &&
                  !march_start && !pix_valid;
      end
      check("march hold", 32'(stable), 32'd1);
      @(negedge clk);
      check("pix_valid", 32'(pix_valid), 32'd1);
      check("pix_shade", 32'(pix_shade), 32'(shade_t[p]));
      check("pix_col", 32'(pix_col), 32'(p % 4));
      check("pix_row", 32'(pix_row), 32'(p / 4));
      check("pix_last", 32'(pix_last), (p == 7) ? 32'd1 : 32'd0);
      if (p == 1) begin
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
          stable &= pix_valid && (pix_shade == 4'd1) && (pix_col == 2'd1) &&
                    (pix_row == 1'b0) && !pix_last && !march_start && (lx_o == LX);
          lx_in = lx_in ^ 16'sh00ff;
          @(negedge clk);
        end
        check("stall hold", 32'(stable), 32'd1);
        pix_ready = 1'b1;
      end
      if (p == 3) pulse_frame_start();
    end
    @(negedge clk);
    check("frame_done pulse", 32'(frame_done), 32'd1);
    check("busy in done", 32'(busy), 32'd1);
    @(negedge clk);
    check("busy idle", 32'(busy), 32'd0);
    check("frame_done drop", 32'(frame_done), 32'd0);
    check("march_start count", 32'(ms_cnt), 32'd8);
    check("frame_done count", 32'(fd_cnt), 32'd1);

    // Frame 2: reset in the middle of pixel (2,0) march.
    lx_in = LX;
    pulse_frame_start();
    for (int j = 0; j < 3; j++) begin
      wait_march();
      if (j < 2) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("pre-reset col", 32'(pix_col), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid rst col", 32'(pix_col), 32'd0);
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst rx_o", 32'(rx_o), 32'd0);
    check("mid rst px_o", 32'(px_o), 32'd0);
    check("mid rst lx_o", 32'(lx_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Frame 3: restart from (0,0) with a new origin.
    cam_px = 16'sh0123;
    pulse_frame_start();
    wait_march();
    check("restart rx_o", 32'(rx_o), 32'(RXB));
    check("restart col", 32'(pix_col), 32'd0);
    check("restart row", 32'(pix_row), 32'd0);
    check("restart px_o", 32'(px_o), 32'(16'sh0123));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
